// File: rtl/gf22_sram_arb_pkg.sv
// Shared definitions for the GF22 64-bit byte-masked SRAM port arbiter.
//   - Default address/data widths of the 8192x64 wrapper.
//   - Minimum response-queue depth.
//   - Width helpers for occupancy counters and queue pointers.
//   - Grant encoding used by the arbiter.
package gf22_sram_arb_pkg;

    localparam int unsigned DefAddrW    = 13;
    localparam int unsigned DefDataW    = 64;
    localparam int unsigned RspDepthMin = 2;

    // Counter must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        GntNone = 2'd0,
        GntWr   = 2'd1,
        GntRd   = 2'd2
    } gnt_e;

endpackage

// File: rtl/gf22_sram64_rsp_fifo.sv
// Response queue for the SRAM port arbiter.
//   CLK        clock, all updates on posedge
//   RST        synchronous active-high reset (empties the queue)
//   push       write push_data at the tail
//   push_data  data to enqueue
//   pop        remove the head entry (ignored when empty)
//   head       current head entry (valid when count != 0)
//   count      number of stored entries, 0..DEPTH
module gf22_sram64_rsp_fifo
    import gf22_sram_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = RspDepthMin,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           push,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic [DATA_W-1:0]              head,
    output logic [cnt_width(DEPTH)-1:0]    count
);

    localparam int unsigned CntW = cnt_width(DEPTH);
    localparam int unsigned PtrW = ptr_width(DEPTH);

    logic [DATA_W-1:0] store_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; count gates its validity.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            store_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = store_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/gf22_sram64_be_port_arbiter.sv
// Round-robin arbiter sharing one single-ported 8192x64 byte-masked SRAM between a
// write requester and a read requester. Reads return through a credit-guarded queue.
//   CLK, RST                                 clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data/wr_mask write request channel (mask: 1 = write bit)
//   rd_valid/rd_ready/rd_addr                read request channel
//   rsp_valid/rsp_ready/rsp_data             read responses, in request order
//   mem_ce0/a0/d0/we0/wem0                   memory write interface
//   mem_ce1/a1, mem_q1                       memory read interface, data one cycle later
module gf22_sram64_be_port_arbiter
    import gf22_sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned RSP_DEPTH = RspDepthMin  // must be >= 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_ce0,
    output logic [ADDR_W-1:0] mem_a0,
    output logic [DATA_W-1:0] mem_d0,
    output logic              mem_we0,
    output logic [DATA_W-1:0] mem_wem0,
    output logic              mem_ce1,
    output logic [ADDR_W-1:0] mem_a1,
    input  logic [DATA_W-1:0] mem_q1
);

    localparam int unsigned CntW = cnt_width(RSP_DEPTH);
    localparam int unsigned SumW = CntW + 1;

    logic [CntW-1:0] occ;
    logic [SumW-1:0] pending;
    logic            inflight_q;
    logic            last_rd_q;
    logic            pop;
    logic            rd_elig;
    logic            rd_ok;
    gnt_e            gnt;

    assign rsp_valid = !RST && (occ != '0);
    assign pop       = rsp_valid && rsp_ready;

    // Queue slots that will be claimed after this cycle; a same-cycle pop frees one.
    assign pending = SumW'(occ) + SumW'(inflight_q) - SumW'(pop);
    assign rd_elig = pending < SumW'(RSP_DEPTH);
    assign rd_ok   = rd_valid && rd_elig;

    // On contention the side not served last wins; last_rd resets to 1 so write goes first.
    always_comb begin
        gnt = GntNone;
        if (!RST) begin
            if (wr_valid && rd_ok) begin
                gnt = last_rd_q ? GntWr : GntRd;
            end else if (wr_valid) begin
                gnt = GntWr;
            end else if (rd_ok) begin
                gnt = GntRd;
            end
        end
    end

    always_comb begin
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        mem_ce0  = 1'b0;
        mem_a0   = '0;
        mem_d0   = '0;
        mem_we0  = 1'b0;
        mem_wem0 = '0;
        mem_ce1  = 1'b0;
        mem_a1   = '0;
        unique case (gnt)
            GntWr: begin
                wr_ready = 1'b1;
                mem_ce0  = 1'b1;
                mem_we0  = 1'b1;
                mem_a0   = wr_addr;
                mem_d0   = wr_data;
                mem_wem0 = wr_mask;
            end
            GntRd: begin
                rd_ready = 1'b1;
                mem_ce1  = 1'b1;
                mem_a1   = rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight_q <= 1'b0;
            last_rd_q  <= 1'b1;
        end else begin
            inflight_q <= (gnt == GntRd);
            if (gnt == GntWr) begin
                last_rd_q <= 1'b0;
            end else if (gnt == GntRd) begin
                last_rd_q <= 1'b1;
            end
        end
    end

    // mem_q1 is valid the cycle after a read grant; capture it then.
    gf22_sram64_rsp_fifo #(
        .DEPTH  (RSP_DEPTH),
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (inflight_q),
        .push_data (mem_q1),
        .pop       (pop),
        .head      (rsp_data),
        .count     (occ)
    );

endmodule
